// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the bus transfer sequencer.
//   - Sequencer state encoding (IDLE / DRIVE / LOAD)
//   - Source and destination register codes as driven on the datapath bus
//   - Default highest legal source/destination codes and a legality helper
package bus_xfer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [4:0] SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3;
  localparam logic [4:0] SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7;
  localparam logic [4:0] SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11;
  localparam logic [4:0] SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
  localparam logic [4:0] SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHIGH = 5'd18, SRC_ZLO = 5'd19;
  localparam logic [4:0] SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_OUTPORT = 5'd23, SRC_CEXT = 5'd24;

  localparam logic [4:0] DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3;
  localparam logic [4:0] DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7;
  localparam logic [4:0] DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11;
  localparam logic [4:0] DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15;
  localparam logic [4:0] DST_HI  = 5'd16, DST_LO  = 5'd17, DST_ZHIGH = 5'd18, DST_ZLO = 5'd19;
  localparam logic [4:0] DST_PC  = 5'd20, DST_MDR = 5'd21, DST_INPORT = 5'd22;
  localparam logic [4:0] DST_OUTPORT = 5'd23;

  localparam int MAX_SRC_DEF = 24;
  localparam int MAX_DST_DEF = 23;

  // A command is legal only when both codes name an existing register.
  function automatic logic code_legal(int src, int dst, int max_src, int max_dst);
    return (src <= max_src) && (dst <= max_dst);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_fifo.sv
// xfer_cmd_fifo: synchronous command FIFO for the bus transfer sequencer.
// Ports:
//   clock, clear      rising-edge clock, async active-high reset of control state
//   push, push_data   write request (ignored when full) and write data
//   pop, pop_data     read request (ignored when empty); pop_data shows the head
//   count             number of stored entries (0..DEPTH)
//   full, empty       status flags derived from count
module xfer_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: queues source/destination transfer commands and replays them
// onto the shared datapath bus, one transfer at a time.
// Ports:
//   clock, clear            rising-edge clock, async active-high reset
//   cmd_valid/src/dst       command offer from the control unit
//   cmd_ready               FIFO has room (registered count only)
//   stall                   holds the sequencer in IDLE/DRIVE
//   bus_sel                 one-hot source select to the bus mux
//   dst_ld                  one-hot destination load enable
//   xfer_done               pulse coincident with dst_ld
//   cmd_err                 pulse after an illegal command is popped and dropped
//   busy                    transfer in flight or commands queued
//   fifo_count              number of queued commands
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CODE_W  = 5,
  parameter int SEL_W   = 32,
  parameter int LD_W    = 32,
  parameter int MAX_SRC = MAX_SRC_DEF,
  parameter int MAX_DST = MAX_DST_DEF
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    cmd_valid,
  input  logic [CODE_W-1:0]       cmd_src,
  input  logic [CODE_W-1:0]       cmd_dst,
  output logic                    cmd_ready,
  input  logic                    stall,
  output logic [SEL_W-1:0]        bus_sel,
  output logic [LD_W-1:0]         dst_ld,
  output logic                    xfer_done,
  output logic                    cmd_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CODE_W-1:0]   src_q;
  logic [CODE_W-1:0]   dst_q;
  logic                err_q;
  logic [2*CODE_W-1:0] head;
  logic [CODE_W-1:0]   head_src;
  logic [CODE_W-1:0]   head_dst;
  logic                head_legal;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  xfer_cmd_fifo #(
    .WIDTH (2*CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push      (push),
    .push_data ({cmd_src, cmd_dst}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_src   = head[2*CODE_W-1:CODE_W];
  assign head_dst   = head[CODE_W-1:0];
  assign head_legal = code_legal(int'(head_src), int'(head_dst), MAX_SRC, MAX_DST);

  // LOAD lasts exactly one cycle, so it may pop the next command just like IDLE;
  // that is what gives back-to-back transfers every two cycles.
  assign pop = ((state == ST_IDLE) || (state == ST_LOAD)) && !fifo_empty && !stall;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = (pop && head_legal) ? ST_DRIVE : ST_IDLE;
      ST_DRIVE: state_nxt = stall ? ST_DRIVE : ST_LOAD;
      ST_LOAD:  state_nxt = (pop && head_legal) ? ST_DRIVE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= pop && !head_legal;
    end
  end

  // Latched fields are only observed in DRIVE/LOAD, so they need no reset.
  always_ff @(posedge clock) begin
    if (pop) begin
      src_q <= head_src;
      dst_q <= head_dst;
    end
  end

  // Outputs decode from registered state and latched fields only.
  assign bus_sel   = ((state == ST_DRIVE) || (state == ST_LOAD)) ? (SEL_W'(1) << src_q) : '0;
  assign dst_ld    = (state == ST_LOAD) ? (LD_W'(1) << dst_q) : '0;
  assign xfer_done = (state == ST_LOAD);
  assign cmd_err   = err_q;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

endmodule
